// File: rtl/seq_not_monitor_if.sv
// Bundles the stimulus and result signals of seq_not_monitor.
// master drives en/clr/dis/b/c; slave is the monitor side.
interface seq_not_monitor_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             en;
  logic             clr;
  logic [NCH-1:0]   dis;
  logic [NCH-1:0]   b;
  logic [NCH-1:0]   c;
  logic [NCH-1:0]   pass_pulse;
  logic [NCH-1:0]   fail_pulse;
  logic [NCH-1:0]   fail_sticky;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             first_fail_valid;
  logic [CH_W-1:0]  first_fail_ch;

  modport master (
    output en, clr, dis, b, c,
    input  pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt,
           first_fail_valid, first_fail_ch
  );

  modport slave (
    input  en, clr, dis, b, c,
    output pass_pulse, fail_pulse, fail_sticky, pass_cnt, fail_cnt,
           first_fail_valid, first_fail_ch
  );
endinterface

// File: rtl/seq_not_monitor.sv
// Per-channel checker for "not (b ##DELAY c)" with disable on dis, pass/fail counters.
// Optional first-fail capture is built only when SEQ_NOT_MONITOR_FIRST_FAIL_EN is defined.
module seq_not_monitor #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DELAY = 1,
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  seq_not_monitor_if.slave mon
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  function automatic logic [4:0] popcnt(input logic [NCH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      n = n + {4'd0, v[k]};
    end
    return n;
  endfunction

  // CNT_W >= 4 and popcount <= 16, so one carry bit is enough to detect overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [4:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  logic [NCH-1:0]   pend_q [DELAY];
  logic [NCH-1:0]   pend_d [DELAY];
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   mature;
  logic [NCH-1:0]   pass_d, pass_q;
  logic [NCH-1:0]   fail_d, fail_q;
  logic [NCH-1:0]   sticky_d, sticky_q;
  logic [CNT_W-1:0] pcnt_d, pcnt_q;
  logic [CNT_W-1:0] fcnt_d, fcnt_q;

  // Slot k holds attempts started k+1 edges ago; dis wipes every slot of its channel.
  always_comb begin
    start  = (mon.en ? mon.b : '0) & ~mon.dis;
    mature = pend_q[DELAY-1] & ~mon.dis;
    pass_d = mature & ~mon.c;
    fail_d = mature & mon.c;

    pend_d[0] = start;
    for (int unsigned k = 1; k < DELAY; k++) begin
      pend_d[k] = pend_q[k-1] & ~mon.dis;
    end

    sticky_d = sticky_q | fail_d;
    pcnt_d   = sat_add(pcnt_q, popcnt(pass_d));
    fcnt_d   = sat_add(fcnt_q, popcnt(fail_d));
    if (mon.clr) begin
      sticky_d = '0;
      pcnt_d   = '0;
      fcnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DELAY; k++) begin
        pend_q[k] <= '0;
      end
      pass_q   <= '0;
      fail_q   <= '0;
      sticky_q <= '0;
      pcnt_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      pend_q   <= pend_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      sticky_q <= sticky_d;
      pcnt_q   <= pcnt_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign mon.pass_pulse  = pass_q;
  assign mon.fail_pulse  = fail_q;
  assign mon.fail_sticky = sticky_q;
  assign mon.pass_cnt    = pcnt_q;
  assign mon.fail_cnt    = fcnt_q;

`ifdef SEQ_NOT_MONITOR_FIRST_FAIL_EN
  logic            ffv_d, ffv_q;
  logic [CH_W-1:0] ffc_d, ffc_q;
  logic            found;

  always_comb begin
    ffv_d = ffv_q;
    ffc_d = ffc_q;
    found = 1'b0;
    if (mon.clr) begin
      ffv_d = 1'b0;
      ffc_d = '0;
    end else if (!ffv_q && (|fail_d)) begin
      ffv_d = 1'b1;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (fail_d[k] && !found) begin
          ffc_d = CH_W'(k);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ffv_q <= 1'b0;
      ffc_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffc_q <= ffc_d;
    end
  end

  assign mon.first_fail_valid = ffv_q;
  assign mon.first_fail_ch    = ffc_q;
`else
  assign mon.first_fail_valid = 1'b0;
  assign mon.first_fail_ch    = '0;
`endif
endmodule
